// File: rtl/idu_pipe_if.sv
// Handshake and decoded-field bundle between IFU, the decode stage and EXU.
// The slave modport is the decode stage; the master modport is the surrounding pipeline.
interface idu_pipe_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic [4:0]      imm_type;
    logic            rs1_ren;
    logic            rs2_ren;
    logic            rd_wen;
    logic            illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd, rs1, rs2, func3, func7,
               imm, imm_type, rs1_ren, rs2_ren, rd_wen, illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd, rs1, rs2, func3, func7,
               imm, imm_type, rs1_ren, rs2_ren, rd_wen, illegal
    );
endinterface

// File: rtl/idu_pipe.sv
// RV64I decode stage: combinational decode into a registered output slot backed by
// a one-entry skid buffer, with flush and illegal-opcode reporting.
module idu_pipe #(
    parameter int unsigned     XLEN   = 64,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    idu_pipe_if.slave   bus
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [XLEN-1:0] imm;
        logic [4:0]      imm_type;
        logic            rs1_ren;
        logic            rs2_ren;
        logic            rd_wen;
        logic            illegal;
    } dec_t;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

    // pc is the most significant field, so the reset image is RST_PC followed by zeros
    localparam dec_t MAIN_RST = dec_t'({RST_PC, {($bits(dec_t) - XLEN){1'b0}}});

    dec_t        dec;
    fmt_e        fmt;
    logic [31:0] inst;
    logic [31:0] imm32;
    logic        wen;

    dec_t main_q, main_d;
    dec_t skid_q, skid_d;
    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic accept;

    always_comb begin
        inst         = bus.in_inst;
        dec          = '0;
        dec.pc       = bus.in_pc;
        dec.opcode   = inst[6:0];
        dec.rd       = inst[11:7];
        dec.func3    = inst[14:12];
        dec.rs1      = inst[19:15];
        dec.rs2      = inst[24:20];
        dec.func7    = inst[31:25];
        imm32        = '0;
        wen          = 1'b0;

        case (inst[6:0])
            7'b0110111, 7'b0010111:                       fmt = FMT_U;
            7'b1101111:                                   fmt = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011,
            7'b1110011, 7'b0001111:                       fmt = FMT_I;
            7'b0100011:                                   fmt = FMT_S;
            7'b1100011:                                   fmt = FMT_B;
            7'b0110011, 7'b0111011:                       fmt = FMT_R;
            default:                                      fmt = FMT_X;
        endcase

        case (fmt)
            FMT_I: begin
                imm32        = {{20{inst[31]}}, inst[31:20]};
                dec.imm_type = 5'b00001;
                dec.rs1_ren  = 1'b1;
                wen          = (inst[6:0] != 7'b0001111);
            end
            FMT_S: begin
                imm32        = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                dec.imm_type = 5'b00010;
                dec.rs1_ren  = 1'b1;
                dec.rs2_ren  = 1'b1;
            end
            FMT_B: begin
                imm32        = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                dec.imm_type = 5'b00100;
                dec.rs1_ren  = 1'b1;
                dec.rs2_ren  = 1'b1;
            end
            FMT_U: begin
                imm32        = {inst[31:12], 12'b0};
                dec.imm_type = 5'b01000;
                wen          = 1'b1;
            end
            FMT_J: begin
                imm32        = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                dec.imm_type = 5'b10000;
                wen          = 1'b1;
            end
            FMT_R: begin
                dec.rs1_ren  = 1'b1;
                dec.rs2_ren  = 1'b1;
                wen          = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        dec.imm    = XLEN'($signed(imm32));
        dec.rd_wen = wen && (inst[11:7] != 5'd0);
    end

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        accept       = bus.in_valid && !skid_valid_q;

        // Accept implies an empty skid, so a skid->main move never competes with a new beat.
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || bus.out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) main_d = dec;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= MAIN_RST;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = main_valid_q;
    assign bus.out_pc    = main_q.pc;
    assign bus.opcode    = main_q.opcode;
    assign bus.rd        = main_q.rd;
    assign bus.rs1       = main_q.rs1;
    assign bus.rs2       = main_q.rs2;
    assign bus.func3     = main_q.func3;
    assign bus.func7     = main_q.func7;
    assign bus.imm       = main_q.imm;
    assign bus.imm_type  = main_q.imm_type;
    assign bus.rs1_ren   = main_q.rs1_ren;
    assign bus.rs2_ren   = main_q.rs2_ren;
    assign bus.rd_wen    = main_q.rd_wen;
    assign bus.illegal   = main_q.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: fixed decode vectors, backpressure ordering, random traffic
// against a reference decoder with an expectation queue, flush and mid-stream reset.
module tb_idu_pipe;

    localparam int unsigned XLEN   = 64;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [63:0] imm;
        logic [4:0]  imm_type;
        logic        rs1_ren;
        logic        rs2_ren;
        logic        rd_wen;
        logic        illegal;
    } dec_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    idu_pipe_if #(.XLEN(XLEN)) bus ();

    idu_pipe #(.XLEN(XLEN), .RST_PC(RST_PC)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    dec_t sb[$];

    function automatic dec_t observe();
        dec_t o;
        o.pc       = bus.out_pc;
        o.opcode   = bus.opcode;
        o.rd       = bus.rd;
        o.rs1      = bus.rs1;
        o.rs2      = bus.rs2;
        o.func3    = bus.func3;
        o.func7    = bus.func7;
        o.imm      = bus.imm;
        o.imm_type = bus.imm_type;
        o.rs1_ren  = bus.rs1_ren;
        o.rs2_ren  = bus.rs2_ren;
        o.rd_wen   = bus.rd_wen;
        o.illegal  = bus.illegal;
        return o;
    endfunction

    // Reference decoder written straight from the opcode table and immediate formulas
    function automatic dec_t ref_decode(logic [31:0] i, logic [63:0] pc);
        dec_t r = '0;
        r.pc     = pc;
        r.opcode = i[6:0];
        r.rd     = i[11:7];
        r.rs1    = i[19:15];
        r.rs2    = i[24:20];
        r.func3  = i[14:12];
        r.func7  = i[31:25];
        case (i[6:0])
            7'h37, 7'h17: begin
                r.imm = {{32{i[31]}}, i[31:12], 12'b0};
                r.imm_type = 5'b01000; r.rd_wen = 1'b1;
            end
            7'h6F: begin
                r.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                r.imm_type = 5'b10000; r.rd_wen = 1'b1;
            end
            7'h67, 7'h03, 7'h13, 7'h1B, 7'h73: begin
                r.imm = {{52{i[31]}}, i[31:20]};
                r.imm_type = 5'b00001; r.rs1_ren = 1'b1; r.rd_wen = 1'b1;
            end
            7'h0F: begin
                r.imm = {{52{i[31]}}, i[31:20]};
                r.imm_type = 5'b00001; r.rs1_ren = 1'b1;
            end
            7'h23: begin
                r.imm = {{52{i[31]}}, i[31:25], i[11:7]};
                r.imm_type = 5'b00010; r.rs1_ren = 1'b1; r.rs2_ren = 1'b1;
            end
            7'h63: begin
                r.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                r.imm_type = 5'b00100; r.rs1_ren = 1'b1; r.rs2_ren = 1'b1;
            end
            7'h33, 7'h3B: begin
                r.rs1_ren = 1'b1; r.rs2_ren = 1'b1; r.rd_wen = 1'b1;
            end
            default: r.illegal = 1'b1;
        endcase
        if (i[11:7] == 5'd0) r.rd_wen = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom();
        case ($urandom_range(0, 15))
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6F;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h03;
            5:  w[6:0] = 7'h13;
            6:  w[6:0] = 7'h1B;
            7:  w[6:0] = 7'h73;
            8:  w[6:0] = 7'h0F;
            9:  w[6:0] = 7'h23;
            10: w[6:0] = 7'h63;
            11: w[6:0] = 7'h33;
            12: w[6:0] = 7'h3B;
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_reset();
        dec_t exp = '0;
        exp.pc = RST_PC;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b0 || observe() !== exp) begin
            n_err++;
            $display("FAIL reset_state: out_valid=%b fields=%h expected out_valid=0 fields=%h",
                     bus.out_valid, observe(), exp);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_spec_vectors();
        logic [31:0] insts [5];
        logic [6:0]  ops   [5];
        logic [4:0]  rds   [5];
        logic [63:0] imms  [5];
        logic [4:0]  types [5];
        logic [3:0]  flags [5];
        insts = '{32'hFFF00093, 32'h123452B7, 32'h008000EF, 32'hFE20BC23, 32'h00000000};
        ops   = '{7'h13, 7'h37, 7'h6F, 7'h23, 7'h00};
        rds   = '{5'd1, 5'd5, 5'd1, 5'd24, 5'd0};
        imms  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1234_5000, 64'd8,
                  64'hFFFF_FFFF_FFFF_FFF8, 64'd0};
        types = '{5'b00001, 5'b01000, 5'b10000, 5'b00010, 5'b00000};
        // {rs1_ren, rs2_ren, rd_wen, illegal}
        flags = '{4'b1010, 4'b0010, 4'b0010, 4'b1100, 4'b0001};
        for (int k = 0; k < 5; k++) begin
            logic [63:0] pc = 64'h1000 + 64'(4 * k);
            @(posedge clk); #1;
            bus.in_valid = 1'b1; bus.in_inst = insts[k]; bus.in_pc = pc; bus.out_ready = 1'b1;
            @(negedge clk);
            n_vec++;
            if (bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL vec%0d_in_ready: got %b expected 1", k, bus.in_ready);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== pc || bus.opcode !== ops[k] ||
                bus.rd !== rds[k] || bus.imm !== imms[k] || bus.imm_type !== types[k] ||
                {bus.rs1_ren, bus.rs2_ren, bus.rd_wen, bus.illegal} !== flags[k]) begin
                n_err++;
                $display("FAIL vec%0d_decode: v=%b pc=%h op=%h rd=%0d imm=%h type=%b flags=%b expected v=1 pc=%h op=%h rd=%0d imm=%h type=%b flags=%b",
                         k, bus.out_valid, bus.out_pc, bus.opcode, bus.rd, bus.imm, bus.imm_type,
                         {bus.rs1_ren, bus.rs2_ren, bus.rd_wen, bus.illegal},
                         pc, ops[k], rds[k], imms[k], types[k], flags[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] insts [3];
        int idx = 0;
        int delivered = 0;
        dec_t exp, got;
        insts = '{32'h00100113, 32'h00208193, 32'h00310213};
        sb.delete();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_inst = insts[0]; bus.in_pc = 64'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) begin
                n_vec++;
                if (bus.in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_in_ready_drop: got %b expected 0", bus.in_ready);
                end
            end
            if (c >= 2) begin
                n_vec++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin
                    n_err++;
                    $display("FAIL bp_hold: out_valid=%b out_pc=%h expected 1/0", bus.out_valid, bus.out_pc);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(ref_decode(bus.in_inst, bus.in_pc));
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 3) begin bus.in_inst = insts[idx]; bus.in_pc = 64'(4 * idx); end
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && delivered < 3; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                n_vec++;
                got = observe();
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra_beat: pc=%h expected no beat", got.pc);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL bp_order: got %h expected %h", got, exp);
                    end
                end
                delivered++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(ref_decode(bus.in_inst, bus.in_pc));
                idx++;
            end
            @(posedge clk); #1;
            bus.in_valid = (idx < 3);
            if (idx < 3) begin bus.in_inst = insts[idx]; bus.in_pc = 64'(4 * idx); end
        end
        n_vec++;
        if (delivered != 3 || sb.size() != 0) begin
            n_err++;
            $display("FAIL bp_count: delivered=%0d pending=%0d expected 3/0", delivered, sb.size());
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          delivered = 0;
        logic        acc = 1'b0;
        logic [63:0] pc_next = 64'h2000;
        dec_t        exp, got;
        sb.delete();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                n_vec++;
                got = observe();
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra_beat: pc=%h expected no beat", got.pc);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL b2b_decode: got %h expected %h", got, exp);
                    end
                end
                delivered++;
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                sb.push_back(ref_decode(bus.in_inst, bus.in_pc));
                sent++;
            end
            @(posedge clk); #1;
            if (c >= 400) begin
                bus.in_valid = 1'b0;
                bus.out_ready = 1'b1;
            end else begin
                if (!bus.in_valid || acc) begin
                    bus.in_valid = (c < 30) || ($urandom_range(0, 9) < 7);
                    if (bus.in_valid) begin
                        bus.in_inst = rand_inst();
                        bus.in_pc = pc_next;
                        pc_next += 64'd4;
                    end
                end
                bus.out_ready = (c < 30) || ($urandom_range(0, 9) < 6);
            end
        end
        n_vec++;
        if (delivered != sent || sb.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: delivered=%0d pending=%0d expected %0d/0", delivered, sb.size(), sent);
        end
    endtask

    task automatic test_flush();
        dec_t exp, got;
        for (int s = 2; s >= 1; s--) begin
            int loaded = 0;
            sb.delete();
            bus.out_ready = 1'b0;
            for (int c = 0; c < 10 && loaded < s; c++) begin
                bus.in_valid = 1'b1; bus.in_inst = 32'h00500093; bus.in_pc = 64'h3000 + 64'(4 * loaded);
                @(negedge clk);
                if (bus.in_ready) loaded++;
                @(posedge clk); #1;
            end
            flush = 1'b1;
            bus.in_valid = 1'b1; bus.in_inst = 32'h00700093; bus.in_pc = 64'hDEAD0;
            @(negedge clk);
            n_vec++;
            if (bus.in_ready !== (s == 1)) begin
                n_err++;
                $display("FAIL flush%0d_pre_ready: in_ready=%b expected %b", s, bus.in_ready, (s == 1));
            end
            @(posedge clk); #1;
            flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                n_vec++;
                if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL flush%0d_drop: cycle %0d out_valid=%b in_ready=%b pc=%h expected 0/1",
                             s, c, bus.out_valid, bus.in_ready, bus.out_pc);
                end
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1; bus.in_inst = 32'h00C0006F; bus.in_pc = 64'hF00 + 64'(s);
            @(negedge clk);
            if (bus.in_ready) sb.push_back(ref_decode(bus.in_inst, bus.in_pc));
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            n_vec++;
            got = observe();
            if (!bus.out_valid || sb.size() == 0) begin
                n_err++;
                $display("FAIL flush%0d_recover: out_valid=%b pending=%0d expected 1/1", s, bus.out_valid, sb.size());
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL flush%0d_recover_data: got %h expected %h", s, got, exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rst_midstream();
        dec_t exp, got;
        sb.delete();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1; bus.in_inst = 32'h00000013; bus.in_pc = 64'h4000 + 64'(4 * k);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out_pc !== RST_PC || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_async: out_valid=%b out_pc=%h in_ready=%b expected 0/%h/1",
                     bus.out_valid, bus.out_pc, bus.in_ready, RST_PC);
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_release_empty: out_valid=%b expected 0", bus.out_valid);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_inst = 32'h0020A023; bus.in_pc = 64'h5000;
        @(negedge clk);
        if (bus.in_ready) sb.push_back(ref_decode(bus.in_inst, bus.in_pc));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        got = observe();
        if (!bus.out_valid || sb.size() == 0) begin
            n_err++;
            $display("FAIL rst_recover: out_valid=%b pending=%0d expected 1/1", bus.out_valid, sb.size());
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                n_err++;
                $display("FAIL rst_recover_data: got %h expected %h", got, exp);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_rst_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, miscompares so far %0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
